// File: rtl/sc_dmem_arbiter.sv
// sc_dmem_arbiter: shares the single-port data RAM between port A (CPU) and port B (loader/debug)
// using round-robin or A-priority arbitration, with a starvation guard for B and an I/O reject for B.
module sc_dmem_arbiter #(
  parameter bit          A_PRIORITY = 1'b0,
  parameter int          MAX_WAIT   = 8,
  parameter logic [23:0] IO_BASE    = 24'hffffff
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [4:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  localparam logic [7:0] MW = 8'(MAX_WAIT);
  logic       last_b, sel_a, sel_b, b_io, b_issue, a_rd, b_rd;
  logic [7:0] wait_cnt;
  always_comb begin
    b_io    = b_addr[31:8] == IO_BASE;
    sel_b   = b_req & (~a_req | (wait_cnt >= MW) | (~A_PRIORITY & ~last_b));
    sel_a   = a_req & ~sel_b;
    b_issue = sel_b & ~b_io;
  end
  assign busy = a_gnt | b_gnt | a_rvalid | b_rvalid;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      b_err     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_rd      <= 1'b0;
      b_rd      <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      last_b    <= 1'b1;
      wait_cnt  <= '0;
    end else begin
      a_gnt    <= sel_a;
      b_gnt    <= b_issue;
      b_err    <= sel_b & b_io;
      mem_we   <= sel_a ? a_we : b_issue & b_we;
      if (sel_a | b_issue) begin
        mem_addr  <= sel_a ? a_addr[6:2] : b_addr[6:2];
        mem_wdata <= sel_a ? a_wdata : b_wdata;
      end
      // read data is captured at the end of the grant cycle
      a_rd     <= sel_a & ~a_we;
      b_rd     <= b_issue & ~b_we;
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      if (a_rd) a_rdata <= mem_rdata;
      if (b_rd) b_rdata <= mem_rdata;
      if (sel_a | sel_b) last_b <= sel_b;
      wait_cnt <= (~b_req | sel_b) ? 8'd0 : wait_cnt + {7'd0, wait_cnt != 8'hff};
    end
  end
endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// tb_sc_dmem_arbiter: runs a round-robin and an A-priority instance side by side on shared stimulus,
// each with its own RAM, against a cycle-level reference model of the arbitration rules.
module tb_sc_dmem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic        a_gnt[2], a_rvalid[2], b_gnt[2], b_rvalid[2], b_err[2], mem_we[2], busy[2];
  logic [31:0] a_rdata[2], b_rdata[2], mem_wdata[2], mem_rdata[2];
  logic [4:0]  mem_addr[2];
  logic [31:0] ram[2][32];
  int n_vec = 0, n_bad = 0;

  function automatic logic [31:0] init_val(int i);
    return (i == 3) ? 32'h12345678 : 32'h01010101 * i ^ 32'ha5a50000;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sc_dmem_arbiter #(.A_PRIORITY(g == 1), .MAX_WAIT(8), .IO_BASE(24'hffffff)) dut (
      .clock(clock), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt[g]), .a_rvalid(a_rvalid[g]), .a_rdata(a_rdata[g]),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt[g]), .b_rvalid(b_rvalid[g]), .b_rdata(b_rdata[g]), .b_err(b_err[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_we(mem_we[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g]));
    assign mem_rdata[g] = ram[g][mem_addr[g]];
    always @(posedge clock)
      if (reset) for (int i = 0; i < 32; i++) ram[g][i] <= init_val(i);
      else if (mem_we[g]) ram[g][mem_addr[g]] <= mem_wdata[g];
  end

  // reference model state
  int          lb[2], wc[2];
  bit          pa[2], pb[2];
  logic [31:0] pad[2], pbd[2], rmem[2][32];
  logic        e_agnt[2], e_bgnt[2], e_berr[2], e_we[2], e_arv[2], e_brv[2];
  logic [4:0]  e_addr[2];
  logic [31:0] e_wd[2], e_ard[2], e_brd[2];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d a_gnt", d), 64'(a_gnt[d]), 64'(e_agnt[d]));
      check($sformatf("d%0d b_gnt", d), 64'(b_gnt[d]), 64'(e_bgnt[d]));
      check($sformatf("d%0d b_err", d), 64'(b_err[d]), 64'(e_berr[d]));
      check($sformatf("d%0d mem_we", d), 64'(mem_we[d]), 64'(e_we[d]));
      check($sformatf("d%0d mem_addr", d), 64'(mem_addr[d]), 64'(e_addr[d]));
      check($sformatf("d%0d mem_wdata", d), 64'(mem_wdata[d]), 64'(e_wd[d]));
      check($sformatf("d%0d a_rvalid", d), 64'(a_rvalid[d]), 64'(e_arv[d]));
      check($sformatf("d%0d b_rvalid", d), 64'(b_rvalid[d]), 64'(e_brv[d]));
      check($sformatf("d%0d a_rdata", d), 64'(a_rdata[d]), 64'(e_ard[d]));
      check($sformatf("d%0d b_rdata", d), 64'(b_rdata[d]), 64'(e_brd[d]));
      check($sformatf("d%0d busy", d), 64'(busy[d]),
            64'(e_agnt[d] | e_bgnt[d] | e_arv[d] | e_brv[d]));
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      lb[d] = 1; wc[d] = 0; pa[d] = 0; pb[d] = 0;
      e_agnt[d] = 0; e_bgnt[d] = 0; e_berr[d] = 0; e_we[d] = 0; e_arv[d] = 0; e_brv[d] = 0;
      e_addr[d] = 0; e_wd[d] = 0; e_ard[d] = 0; e_brd[d] = 0;
      for (int i = 0; i < 32; i++) rmem[d][i] = init_val(i);
    end
  endtask

  // asynchronous: outputs must read as reset values right after reset rises
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1 compare_all();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      bit wa, wb, io;
      io = b_addr[31:8] == 24'hffffff;
      if (a_req && b_req) wb = (wc[d] >= 8) || (d == 0 && lb[d] == 0);
      else wb = b_req;
      wa = a_req && !wb;
      e_arv[d] = pa[d];
      if (pa[d]) e_ard[d] = pad[d];
      e_brv[d] = pb[d];
      if (pb[d]) e_brd[d] = pbd[d];
      pa[d]  = wa && !a_we;
      pad[d] = rmem[d][a_addr[6:2]];
      pb[d]  = wb && !io && !b_we;
      pbd[d] = rmem[d][b_addr[6:2]];
      e_agnt[d] = wa;
      e_bgnt[d] = wb && !io;
      e_berr[d] = wb && io;
      e_we[d]   = wa ? a_we : (wb && !io && b_we);
      if (wa) begin e_addr[d] = a_addr[6:2]; e_wd[d] = a_wdata; end
      else if (wb && !io) begin e_addr[d] = b_addr[6:2]; e_wd[d] = b_wdata; end
      if (e_we[d]) rmem[d][e_addr[d]] = e_wd[d];
      if (wa || wb) lb[d] = wb ? 1 : 0;
      wc[d] = (!b_req || wb) ? 0 : (wc[d] < 255 ? wc[d] + 1 : 255);
    end
    #1 compare_all();
  endtask

  task automatic idle();
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
  endtask

  initial begin
    do_reset();
    // A read of word 3
    a_req = 1; a_we = 0; a_addr = 32'h0000000c;
    step();
    check("a_read gnt", 64'(a_gnt[0]), 64'd1);
    check("a_read mem_addr", 64'(mem_addr[0]), 64'd3);
    idle();
    step();
    check("a_read rvalid", 64'(a_rvalid[0]), 64'd1);
    check("a_read rdata", 64'(a_rdata[0]), 64'h12345678);
    // both request continuously: alternate on d0, 8A:1B on d1
    do_reset();
    a_req = 1; b_req = 1; a_addr = 32'h4; b_addr = 32'h8;
    for (int i = 0; i < 18; i++) begin
      step();
      check($sformatf("rr b_gnt %0d", i), 64'(b_gnt[0]), 64'(i % 2));
      check($sformatf("prio b_gnt %0d", i), 64'(b_gnt[1]), 64'(i % 9 == 8));
    end
    idle();
    step();
    // B write into the I/O region is rejected
    b_req = 1; b_we = 1; b_addr = 32'hffffff20; b_wdata = 32'h7f;
    step();
    check("io b_err", 64'(b_err[0]), 64'd1);
    check("io b_gnt", 64'(b_gnt[0]), 64'd0);
    check("io mem_we", 64'(mem_we[0]), 64'd0);
    // B write then read back
    b_addr = 32'h10; b_wdata = 32'hdeadbeef;
    step();
    check("bw mem_we", 64'(mem_we[0]), 64'd1);
    check("bw mem_addr", 64'(mem_addr[0]), 64'd4);
    b_we = 0;
    step();
    idle();
    step();
    check("br b_rvalid", 64'(b_rvalid[0]), 64'd1);
    check("br b_rdata", 64'(b_rdata[0]), 64'hdeadbeef);
    // reset during an in-flight read
    a_req = 1; a_we = 0; a_addr = 32'h20;
    step();
    idle();
    #2 do_reset();
    step();
    check("rst no a_rvalid", 64'(a_rvalid[0]), 64'd0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a_req = $urandom_range(0, 3) != 0;
      b_req = $urandom_range(0, 3) != 0;
      a_we = $urandom_range(0, 1) == 1;
      b_we = $urandom_range(0, 1) == 1;
      a_addr = {($urandom_range(0, 3) == 0) ? 24'hffffff : 24'($urandom), 8'($urandom)};
      b_addr = {($urandom_range(0, 3) == 0) ? 24'hffffff : 24'($urandom_range(0, 255)), 8'($urandom)};
      a_wdata = $urandom;
      b_wdata = $urandom;
      if (i == 1500) begin
        #2 do_reset();
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sc_dmem_arbiter.md
Name: sc_dmem_arbiter

Overview:
Shares the single-port data RAM (32 words, word-addressed by addr[6:2]) between two requesters: port A (CPU-side bus master) and port B (loader/debug master used to preload or inspect data memory). It arbitrates with round-robin order, an optional A-priority mode and a port-B starvation guard. It registers the winning command onto the RAM port and returns read data with a fixed latency. It sits between the masters and the RAM, upstream of the memory-mapped I/O decode.

Parameters:
A_PRIORITY, 0, 1 = port A always wins a conflict (subject to starvation guard); 0 = round-robin
MAX_WAIT, 8, cycles port B may be denied while requesting before it is force-granted (1..255)
IO_BASE, 24'hffffff, addr[31:8] value marking the I/O region; port B commands to it are rejected

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
a_req  in  1  port A request; held until a_gnt
a_we  in  1  port A write (1) / read (0)
a_addr  in  32  port A byte address
a_wdata  in  32  port A write data
a_gnt  out  1  one-cycle pulse: A command issued to RAM this cycle
a_rvalid  out  1  one-cycle pulse: a_rdata valid
a_rdata  out  32  read data for port A
b_req, b_we, b_addr, b_wdata  in  1/1/32/32  port B equivalents
b_gnt, b_rvalid  out  1  port B equivalents
b_rdata  out  32  read data for port B
b_err  out  1  one-cycle pulse: B command to I/O region rejected
mem_addr  out  5  RAM word address (= winner addr[6:2])
mem_wdata  out  32  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  32  RAM read data, valid one cycle after command
busy  out  1  command in flight on RAM port

Behaviour:
- Reset (async, active-high): all gnt/rvalid/err/mem_we/busy = 0; mem_addr = 0; mem_wdata = 0; rdata outputs = 0; last_grant = B (so A wins first tie); wait counter = 0.
- Cycle t edge: sample requests and select the winner; cycle t+1: gnt_x = 1 and mem_* driven with the winner's fields; cycle t+2: for a read, rdata_x = mem_rdata captured at the t+2 edge and rvalid_x = 1. Read latency req→rvalid = 2 cycles; write completes at gnt.
- Throughput: one command per cycle; back-to-back grants allowed; the requester must drop or renew its req in the gnt cycle. A req still high in the gnt cycle counts as a new request.
- Arbitration when both request:
  - A_PRIORITY=0: grant the port other than last_grant.
  - A_PRIORITY=1: grant A.
  - Override: if wait counter ≥ MAX_WAIT, grant B.
- Single request: grant it immediately.
- Wait counter: increments each cycle b_req=1 and B is not selected; clears on a B grant or when b_req=0; saturates at 255.
- I/O guard: B command with addr[31:8]==IO_BASE is not issued to RAM. b_err pulses in the would-be gnt cycle, with no b_gnt, no b_rvalid and mem_we=0. This still consumes B's turn, and last_grant updates to B.
- Port A has no I/O guard; the downstream decoder handles it.
- mem_we = 1 only in a write-grant cycle; otherwise 0. mem_addr and mem_wdata hold their last value when idle.
- busy = 1 in any gnt cycle or rvalid cycle.
- Reset mid-operation: in-flight read is dropped (no rvalid); state returns to reset values.
- Neither request: no grant; last_grant unchanged.

Test Plan:
- Reset, then A read of addr 0x0000000C with mem_rdata=0x12345678 → a_gnt at t+1 with mem_addr=3 and mem_we=0; a_rvalid at t+2 with a_rdata=0x12345678.
- A and B request continuously, A_PRIORITY=0 → grants alternate A,B,A,B; first grant goes to A.
- A_PRIORITY=1, MAX_WAIT=8, both request continuously → 8 A grants, then 1 B grant, then the pattern repeats; wait counter returns to 0 after the B grant.
- B write to 0xFFFFFF20 with data 0x7F → b_err pulse, mem_we stays 0, no b_gnt.
- B write 0xDEADBEEF to 0x00000010, then B read of the same address → mem_we=1 with mem_addr=4 in the first gnt cycle; b_rdata=0xDEADBEEF on the read's b_rvalid.
- A read granted, reset asserted in the following cycle → no a_rvalid; all outputs at reset values immediately (asynchronous).
